fsk_period_demod: RTL and testbench

- Receive-side counterpart of the modulation path's mod-M tick/tone divider. It works in the opposite direction: it measures the period of an incoming square carrier from the transducer comparator and converts that count back into mark/space bits.
- Input is an asynchronous comparator output. Outputs are a demodulated bit, a one-cycle decision strobe, a carrier-present flag and the last measured period.
- Sits between the analog front-end comparator and the downstream bit framer/UART receiver.

---
 rtl/fsk_pkg.sv | 40 ++++
 rtl/fsk_period_demod_if.sv | 21 ++
 rtl/sync_edge_det.sv | 23 ++
 rtl/fsk_period_demod.sv | 162 ++++++++++++++++
 tb/tb_fsk_period_demod.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/fsk_pkg.sv
// Shared FSK definitions: demodulator state/class encodings and the carrier
// periods the TX divider and RX demodulator must agree on.
package fsk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CLS_INVALID = 2'd0,
        CLS_MARK    = 2'd1,
        CLS_SPACE   = 2'd2
    } class_t;

    // Nominal carrier periods in clk cycles at 50 MHz (40 kHz mark, ~36 kHz space)
    localparam int unsigned MARK_PERIOD   = 1250;
    localparam int unsigned SPACE_PERIOD  = 1400;

    localparam int unsigned N_DEF         = 16;
    localparam int unsigned MARK_MIN_DEF  = 1200;
    localparam int unsigned MARK_MAX_DEF  = 1300;
    localparam int unsigned SPACE_MIN_DEF = 1350;
    localparam int unsigned SPACE_MAX_DEF = 1450;
    localparam int unsigned CONFIRM_DEF   = 4;

    function automatic class_t classify(
        input int unsigned p,
        input int unsigned mark_min,
        input int unsigned mark_max,
        input int unsigned space_min,
        input int unsigned space_max
    );
        if (p >= mark_min && p <= mark_max) return CLS_MARK;
        if (p >= space_min && p <= space_max) return CLS_SPACE;
        return CLS_INVALID;
    endfunction

endpackage

// File: rtl/fsk_period_demod_if.sv
// Control/result bundle between the demodulator and its surroundings.
interface fsk_period_demod_if #(
    parameter int unsigned N = 16
);
    logic         en;
    logic         fsk_in;
    logic         bit_out;
    logic         bit_valid;
    logic         carrier_ok;
    logic [N-1:0] period;

    modport master (
        output en, fsk_in,
        input  bit_out, bit_valid, carrier_ok, period
    );

    modport slave (
        input  en, fsk_in,
        output bit_out, bit_valid, carrier_ok, period
    );
endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
// An input rising edge appears on rise three clk edges later.
module sync_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);
    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], async_in};
            prev_q <= sync_q[1];
            rise   <= sync_q[1] & ~prev_q;
        end
    end
endmodule

// File: rtl/fsk_period_demod.sv
// Period-counting FSK demodulator: classifies each carrier period as mark or
// space and commits a bit after CONFIRM consecutive periods of one class.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no carrier; waiting for the first edge to start timing
// MEASURE | timing periods, building a run towards the first decision
// LOCKED  | carrier present; bit_out follows confirmed class changes
module fsk_period_demod
    import fsk_pkg::*;
#(
    parameter int unsigned N         = N_DEF,
    parameter int unsigned MARK_MIN  = MARK_MIN_DEF,
    parameter int unsigned MARK_MAX  = MARK_MAX_DEF,
    parameter int unsigned SPACE_MIN = SPACE_MIN_DEF,
    parameter int unsigned SPACE_MAX = SPACE_MAX_DEF,
    parameter int unsigned CONFIRM   = CONFIRM_DEF
) (
    input  logic               clk,
    input  logic               reset,
    fsk_period_demod_if.slave  bus
);
    localparam int RW = $clog2(CONFIRM + 1);
    localparam logic [N-1:0]  CNT_MAX  = '1;
    localparam logic [RW-1:0] RUN_FULL = RW'(CONFIRM);

    state_t        state_q, state_d;
    class_t        last_cls_q, last_cls_d, cls;
    logic [N-1:0]  cnt_q;
    logic [N-1:0]  period_q, period_d;
    logic [RW-1:0] run_q, run_d, run_next;
    logic          bit_q, bit_d;
    logic          valid_q, valid_d;
    logic          ok_q, ok_d;
    logic          rise;

    sync_edge_det u_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (bus.fsk_in),
        .rise     (rise)
    );

    // Free-running period counter; value at a rise is the period just ended
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (rise) begin
            cnt_q <= N'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + N'(1);
        end
    end

    always_comb begin
        cls = classify(32'(cnt_q), MARK_MIN, MARK_MAX, SPACE_MIN, SPACE_MAX);
        run_next = '0;
        if (cls != CLS_INVALID) begin
            if (cls == last_cls_q) begin
                run_next = (run_q == RUN_FULL) ? run_q : run_q + RW'(1);
            end else begin
                run_next = RW'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        last_cls_d = last_cls_q;
        bit_d      = bit_q;
        valid_d    = 1'b0;
        period_d   = period_q;

        if (!bus.en) begin
            state_d    = ST_IDLE;
            run_d      = '0;
            last_cls_d = CLS_INVALID;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_d    = ST_MEASURE;
                        run_d      = '0;
                        last_cls_d = CLS_INVALID;
                    end
                end
                ST_MEASURE: begin
                    if (rise) begin
                        period_d   = cnt_q;
                        run_d      = run_next;
                        last_cls_d = cls;
                        if (run_next == RUN_FULL) begin
                            bit_d   = (cls == CLS_MARK);
                            valid_d = 1'b1;
                            state_d = ST_LOCKED;
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        state_d    = ST_IDLE;
                        run_d      = '0;
                        last_cls_d = CLS_INVALID;
                    end
                end
                ST_LOCKED: begin
                    if (rise) begin
                        period_d = cnt_q;
                        if (cls == CLS_INVALID) begin
                            state_d    = ST_MEASURE;
                            run_d      = '0;
                            last_cls_d = CLS_INVALID;
                        end else begin
                            run_d      = run_next;
                            last_cls_d = cls;
                            // Only a confirmed run of the other class moves the bit
                            if (run_next == RUN_FULL && (cls == CLS_MARK) != bit_q) begin
                                bit_d   = ~bit_q;
                                valid_d = 1'b1;
                            end
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        state_d    = ST_IDLE;
                        run_d      = '0;
                        last_cls_d = CLS_INVALID;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    run_d      = '0;
                    last_cls_d = CLS_INVALID;
                end
            endcase
        end

        ok_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            run_q      <= '0;
            last_cls_q <= CLS_INVALID;
            bit_q      <= 1'b1;
            valid_q    <= 1'b0;
            ok_q       <= 1'b0;
            period_q   <= '0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            last_cls_q <= last_cls_d;
            bit_q      <= bit_d;
            valid_q    <= valid_d;
            ok_q       <= ok_d;
            period_q   <= period_d;
        end
    end

    assign bus.bit_out    = bit_q;
    assign bus.bit_valid  = valid_q;
    assign bus.carrier_ok = ok_q;
    assign bus.period     = period_q;

endmodule

// File: tb/tb_fsk_period_demod.sv
// Directed bench for fsk_period_demod: stimulus queues expected bit decisions,
// a negedge monitor checks every bit_valid pulse against that queue.
module tb_fsk_period_demod;

    // Narrower counter so the carrier-loss timeout is 4095 clk instead of 65535
    localparam int N = 12;

    typedef struct {
        logic         b;
        logic [N-1:0] p;
        int unsigned  at;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    int unsigned cyc = 0;
    int unsigned last_edge = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb_q[$];
    exp_t        mon_e;

    fsk_period_demod_if #(.N(N)) bus ();

    fsk_period_demod #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_until(input int unsigned t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step(input int unsigned n);
        wait_until(cyc + n);
    endtask

    task automatic first_edge();
        step(4);
        bus.fsk_in = 1'b1;
        last_edge  = cyc;
    endtask

    // One carrier period of K clk ending in a rising edge; optionally queue the decision it causes
    task automatic period(input int unsigned k, input bit pulse, input bit b);
        exp_t e;
        wait_until(last_edge + k / 2);
        bus.fsk_in = 1'b0;
        wait_until(last_edge + k);
        bus.fsk_in = 1'b1;
        last_edge  = cyc;
        if (pulse) begin
            e.b  = b;
            e.p  = N'(k);
            e.at = cyc + 4;
            sb_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (reset && bus.bit_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bit_valid: pulse at cycle %0d bit_out=%0d, none expected",
                         cyc, bus.bit_out);
            end else begin
                mon_e = sb_q.pop_front();
                check("pulse_cycle", cyc, mon_e.at);
                check("pulse_bit", bus.bit_out, mon_e.b);
                check("pulse_period", bus.period, mon_e.p);
                check("pulse_carrier", bus.carrier_ok, 1);
            end
        end
    end

    initial begin
        #800_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        int unsigned c;
        int unsigned c_k[4] = '{1350, 1450, 1400, 1400};
        int unsigned d_k[4] = '{1200, 1250, 1250, 1250};

        bus.en     = 1'b0;
        bus.fsk_in = 1'b0;
        @(posedge clk);
        #1;
        step(3);
        check("rst_bit_out", bus.bit_out, 1);
        check("rst_bit_valid", bus.bit_valid, 0);
        check("rst_carrier", bus.carrier_ok, 0);
        check("rst_period", bus.period, 0);
        reset  = 1'b1;
        bus.en = 1'b1;
        step(5);

        // Initial lock on a 1250-clk mark carrier
        first_edge();
        step(5);
        check("A_first_edge_period", bus.period, 0);
        for (int i = 1; i <= 4; i++) begin
            period(1250, i == 4, 1'b1);
            step(5);
            check("A_carrier", bus.carrier_ok, (i == 4) ? 1 : 0);
            check("A_period", bus.period, 1250);
        end

        // Three space periods then mark: no decision
        for (int i = 0; i < 3; i++) begin
            period(1400, 1'b0, 1'b0);
            step(5);
            check("B_bit", bus.bit_out, 1);
            check("B_carrier", bus.carrier_ok, 1);
        end
        period(1300, 1'b0, 1'b0);
        step(5);
        check("B_bit_after_mark", bus.bit_out, 1);
        check("B_period", bus.period, 1300);

        // Four space periods (band edges included): toggle to 0
        for (int i = 0; i < 4; i++) begin
            period(c_k[i], i == 3, 1'b0);
            step(5);
            check("C_bit", bus.bit_out, (i == 3) ? 0 : 1);
            check("C_carrier", bus.carrier_ok, 1);
            check("C_period", bus.period, c_k[i]);
        end

        // Out-of-band period drops lock; four marks re-lock
        period(1320, 1'b0, 1'b0);
        step(5);
        check("D_carrier", bus.carrier_ok, 0);
        check("D_bit_hold", bus.bit_out, 0);
        check("D_period", bus.period, 1320);
        for (int i = 0; i < 4; i++) begin
            period(d_k[i], i == 3, 1'b1);
            step(5);
            check("D_relock_carrier", bus.carrier_ok, (i == 3) ? 1 : 0);
            check("D_relock_bit", bus.bit_out, (i == 3) ? 1 : 0);
        end

        // Enable dropped for 10 clk while locked
        wait_until(last_edge + 100);
        bus.en = 1'b0;
        step(10);
        check("E_carrier", bus.carrier_ok, 0);
        check("E_bit_hold", bus.bit_out, 1);
        check("E_period_hold", bus.period, 1250);
        bus.en = 1'b1;
        period(1350, 1'b0, 1'b0);
        step(5);
        check("E_first_edge_period", bus.period, 1250);
        for (int i = 0; i < 4; i++) begin
            period(1350, i == 3, 1'b0);
            step(5);
            check("E_relock_carrier", bus.carrier_ok, (i == 3) ? 1 : 0);
        end

        // Carrier removed: timeout back to IDLE
        c = last_edge;
        wait_until(c + 675);
        bus.fsk_in = 1'b0;
        wait_until(c + 4096);
        check("F_before_timeout", bus.carrier_ok, 1);
        wait_until(c + 4101);
        check("F_after_timeout", bus.carrier_ok, 0);
        check("F_bit_hold", bus.bit_out, 0);
        check("F_period_hold", bus.period, 1350);
        first_edge();
        step(5);
        check("F_first_edge_period", bus.period, 1350);
        for (int i = 0; i < 4; i++) begin
            period(1400, i == 3, 1'b0);
            step(5);
            check("F_relock_carrier", bus.carrier_ok, (i == 3) ? 1 : 0);
        end

        // Asynchronous reset while locked, then re-lock
        wait_until(last_edge + 300);
        reset      = 1'b0;
        bus.fsk_in = 1'b0;
        #2;
        check("G_rst_bit_out", bus.bit_out, 1);
        check("G_rst_carrier", bus.carrier_ok, 0);
        check("G_rst_period", bus.period, 0);
        check("G_rst_bit_valid", bus.bit_valid, 0);
        @(posedge clk);
        #1;
        step(3);
        reset = 1'b1;
        step(3);
        first_edge();
        for (int i = 0; i < 4; i++) begin
            period(1250, i == 3, 1'b1);
            step(5);
            check("G_relock_carrier", bus.carrier_ok, (i == 3) ? 1 : 0);
            check("G_relock_period", bus.period, 1250);
        end

        step(20);
        check("pending_decisions", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
